// File: rtl/snake_body_streamer.sv
// Snake body store: a circular buffer of {y,x} segments with head advance,
// growth, wall/self collision detection and a head-first segment stream.
module snake_body_streamer #(
  parameter int unsigned H        = 32,
  parameter int unsigned V        = 32,
  parameter int unsigned MAX_LEN  = 64,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned INIT_X   = 16,
  parameter int unsigned INIT_Y   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                move_enable,
  input  logic [1:0]                          move,
  input  logic                                step,
  input  logic                                grow,
  input  logic                                shift_req,
  output logic [$clog2(H)-1:0]                seg_x,
  output logic [$clog2(V)-1:0]                seg_y,
  output logic                                seg_valid,
  output logic                                shift_done,
  output logic                                game_over,
  output logic [$clog2(V)+$clog2(H)-1:0]      head,
  output logic [$clog2(MAX_LEN):0]            length
);

  localparam int unsigned XW = $clog2(H);
  localparam int unsigned YW = $clog2(V);
  localparam int unsigned PW = $clog2(MAX_LEN);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = YW + XW;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  logic [CW-1:0] body_mem [MAX_LEN];

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] init_cnt;
  logic [LW-1:0] rd_cnt;
  logic [1:0]    dir;
  logic          step_pend;
  logic          grow_pend;
  logic          shift_pend;
  logic          seg_body;

  logic [XW-1:0] head_x_c;
  logic [YW-1:0] head_y_c;
  logic [XW-1:0] nxt_x_c;
  logic [YW-1:0] nxt_y_c;
  logic          wall_hit_c;
  logic          step_go_c;
  logic          shift_go_c;
  logic          init_last_c;
  logic          stream_end_c;
  logic [PW-1:0] rd_idx_c;
  logic [CW-1:0] rd_data_c;
  logic [XW-1:0] init_x_c;

  assign head_x_c     = head[XW-1:0];
  assign head_y_c     = head[CW-1:XW];
  assign step_go_c    = (step | step_pend) & ~game_over;
  assign shift_go_c   = shift_req | shift_pend;
  assign init_last_c  = (init_cnt == PW'(INIT_LEN - 1));
  assign stream_end_c = (rd_cnt == length);
  assign rd_idx_c     = head_ptr - rd_cnt[PW-1:0];
  assign rd_data_c    = body_mem[rd_idx_c];
  assign init_x_c     = XW'(INIT_X - INIT_LEN + 1 + 32'(init_cnt));

  // Candidate next head and wall detection for the current direction
  always_comb begin
    nxt_x_c    = head_x_c;
    nxt_y_c    = head_y_c;
    wall_hit_c = 1'b0;
    case (dir)
      DIR_RIGHT: begin
        if (head_x_c == XW'(H - 1)) wall_hit_c = 1'b1;
        else                        nxt_x_c    = head_x_c + XW'(1);
      end
      DIR_UP: begin
        if (head_y_c == '0) wall_hit_c = 1'b1;
        else                nxt_y_c    = head_y_c - YW'(1);
      end
      DIR_LEFT: begin
        if (head_x_c == '0) wall_hit_c = 1'b1;
        else                nxt_x_c    = head_x_c - XW'(1);
      end
      default: begin
        if (head_y_c == YW'(V - 1)) wall_hit_c = 1'b1;
        else                        nxt_y_c    = head_y_c + YW'(1);
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  // Next-state logic; a step always wins over a stream request in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   if (init_last_c) state_nxt = S_IDLE;
      S_IDLE: begin
        if (step_go_c)       state_nxt = S_STEP;
        else if (shift_go_c) state_nxt = S_RD;
      end
      S_STEP:   state_nxt = S_IDLE;
      S_RD:     state_nxt = S_STREAM;
      S_STREAM: if (stream_end_c) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_INIT;
    endcase
  end

  // Body buffer writes: initial line during INIT, new head on a legal step
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      body_mem[init_cnt] <= {YW'(INIT_Y), init_x_c};
    end else if (state == S_STEP && !wall_hit_c) begin
      body_mem[head_ptr + PW'(1)] <= {nxt_y_c, nxt_x_c};
    end
  end

  // Control, request latching, snake state and stream outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_x      <= '0;
      seg_y      <= '0;
      seg_valid  <= 1'b0;
      seg_body   <= 1'b0;
      shift_done <= 1'b0;
      game_over  <= 1'b0;
      dir        <= DIR_RIGHT;
      length     <= LW'(INIT_LEN);
      head       <= {YW'(INIT_Y), XW'(INIT_X)};
      head_ptr   <= PW'(INIT_LEN - 1);
      init_cnt   <= '0;
      rd_cnt     <= '0;
      step_pend  <= 1'b0;
      grow_pend  <= 1'b0;
      shift_pend <= 1'b0;
    end else begin
      seg_valid  <= 1'b0;
      seg_body   <= 1'b0;
      shift_done <= 1'b0;

      // A direct reversal would fold the head onto the neck, so it is ignored
      if (move_enable && (move != (dir ^ 2'b10))) dir <= move;

      if (state == S_IDLE) begin
        step_pend  <= 1'b0;
        shift_pend <= step_go_c ? (shift_pend | shift_req) : 1'b0;
      end else begin
        step_pend  <= step_pend | step;
        shift_pend <= shift_pend | shift_req;
      end
      grow_pend <= (state == S_STEP) ? grow : (grow_pend | grow);

      // Any streamed body segment sitting on the head is a self collision
      if (seg_valid && seg_body && ({seg_y, seg_x} == head)) game_over <= 1'b1;

      case (state)
        S_INIT: init_cnt <= init_cnt + PW'(1);
        S_IDLE: rd_cnt <= '0;
        S_STEP: begin
          if (wall_hit_c) begin
            game_over <= 1'b1;
          end else begin
            head     <= {nxt_y_c, nxt_x_c};
            head_ptr <= head_ptr + PW'(1);
            if (grow_pend && (length < LW'(MAX_LEN))) length <= length + LW'(1);
          end
        end
        S_RD, S_STREAM: begin
          if (!stream_end_c) begin
            seg_x     <= rd_data_c[XW-1:0];
            seg_y     <= rd_data_c[CW-1:XW];
            seg_valid <= 1'b1;
            seg_body  <= (rd_cnt != '0);
            rd_cnt    <= rd_cnt + LW'(1);
          end else begin
            shift_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
